// File: rtl/unsigned_sqrt_core.sv
// Iterative restoring square root: one result bit per cycle, two radicand bits consumed per cycle.
// Returns floor(sqrt(radicand)) and radicand - result^2 with a fixed latency and a one-cycle done pulse.
module unsigned_sqrt_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] radicand,
  input  logic                  flush,
  output logic [DATA_WIDTH-1:0] result,
  output logic [DATA_WIDTH-1:0] remainder,
  output logic                  done,
  output logic                  busy
);

  localparam int HALF = DATA_WIDTH / 2;
  localparam int CW   = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int RW   = HALF + 2;

  typedef enum logic [0:0] {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] rad_q, rad_d;
  logic [HALF-1:0]       q_q, q_d;
  logic [RW-1:0]         r_q, r_d;
  logic [DATA_WIDTH-1:0] result_q, result_d;
  logic [DATA_WIDTH-1:0] remainder_q, remainder_d;
  logic                  done_q, done_d;
  logic                  busy_q;
  logic [RW+1:0]         r_sh;
  logic [RW+1:0]         trial;

  // Next-state, datapath iteration and completion capture
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rad_d       = rad_q;
    q_d         = q_q;
    r_d         = r_q;
    result_d    = result_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
    // Widened by two bits so the compare below is exact regardless of r's top bits
    r_sh        = {r_q, rad_q[DATA_WIDTH-1 -: 2]};
    trial       = {2'b00, q_q, 2'b01};

    case (state_q)
      S_IDLE: begin
        if (start && !flush) begin
          state_d = S_BUSY;
          rad_d   = radicand;
          q_d     = '0;
          r_d     = '0;
          cnt_d   = CW'(HALF - 1);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        rad_d = {rad_q[DATA_WIDTH-3:0], 2'b00};
        if (r_sh >= trial) begin
          r_d = RW'(r_sh - trial);
          q_d = {q_q[HALF-2:0], 1'b1};
        end else begin
          r_d = RW'(r_sh);
          q_d = {q_q[HALF-2:0], 1'b0};
        end
        if (cnt_q == '0) begin
          state_d     = S_IDLE;
          result_d    = {{(DATA_WIDTH-HALF){1'b0}}, q_d};
          remainder_d = {{(DATA_WIDTH-HALF-1){1'b0}}, r_d[HALF:0]};
          done_d      = 1'b1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over everything, including a completion on the same edge
    if (flush) begin
      state_d     = S_IDLE;
      done_d      = 1'b0;
      result_d    = result_q;
      remainder_d = remainder_q;
    end else begin
      done_d = done_d;
    end
  end

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rad_q       <= '0;
      q_q         <= '0;
      r_q         <= '0;
      result_q    <= '0;
      remainder_q <= '0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rad_q       <= rad_d;
      q_q         <= q_d;
      r_q         <= r_d;
      result_q    <= result_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      busy_q      <= (state_d == S_BUSY);
    end
  end

  assign result    = result_q;
  assign remainder = remainder_q;
  assign done      = done_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_unsigned_sqrt_core.sv
// Self-checking bench for unsigned_sqrt_core: vector table, corner sequences and a random
// regression, all scored through a queue of expected completions checked when done fires.
module tb_unsigned_sqrt_core;

  localparam int DW   = 32;
  localparam int HALF = DW / 2;
  localparam int LAT  = HALF + 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] radicand = '0;
  logic          flush = 1'b0;
  logic [DW-1:0] result;
  logic [DW-1:0] remainder;
  logic          done;
  logic          busy;

  unsigned_sqrt_core #(.DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .radicand  (radicand),
    .flush     (flush),
    .result    (result),
    .remainder (remainder),
    .done      (done),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] rad;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
  } vec_t;

  typedef struct {
    logic [DW-1:0] rad;
    logic [DW-1:0] res;
    logic [DW-1:0] rem;
    int            cyc;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   busy_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Independent reference: binary search on the square
  function automatic logic [DW-1:0] ref_sqrt(input logic [DW-1:0] x);
    longint unsigned lo, hi, mid;
    lo = 0;
    hi = (64'd1 << HALF) - 64'd1;
    while (lo < hi) begin
      mid = (lo + hi + 64'd1) / 64'd2;
      if (mid * mid <= {32'd0, x}) lo = mid;
      else hi = mid - 64'd1;
    end
    return DW'(lo);
  endfunction

  // Monitor: score every completion against the queue head
  always @(negedge clk) begin
    if (busy) busy_cnt <= busy_cnt + 1;
    if (done) begin
      if (sb_q.size() == 0) begin
        chk("spurious_done", {63'd0, done}, 64'd0);
      end else begin
        exp_t e;
        logic [63:0] r64, m64;
        e = sb_q.pop_front();
        r64 = {32'd0, result};
        m64 = {32'd0, remainder};
        chk("latency", 64'(cyc), 64'(e.cyc));
        chk("result", r64, {32'd0, e.res});
        chk("remainder", m64, {32'd0, e.rem});
        chk("sq_plus_rem", r64 * r64 + m64, {32'd0, e.rad});
        chk("rem_le_2res", {63'd0, (m64 <= 64'd2 * r64)}, 64'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [DW-1:0] rad, input logic [DW-1:0] res,
                       input logic [DW-1:0] rem, input bit expect_done);
    exp_t e;
    start    = 1'b1;
    radicand = rad;
    if (expect_done) begin
      e.rad = rad; e.res = res; e.rem = rem; e.cyc = cyc + LAT;
      sb_q.push_back(e);
    end
    tick();
    start = 1'b0;
  endtask

  task automatic wait_drain(input int bound);
    int n;
    n = 0;
    while (sb_q.size() != 0 && n < bound) begin
      tick();
      n++;
    end
    if (sb_q.size() != 0) begin
      chk("done_timeout", 64'(sb_q.size()), 64'd0);
      sb_q.delete();
    end
  endtask

  vec_t vecs[12];

  initial begin
    logic [DW-1:0] x, rs;
    vecs[0]  = '{32'd0,          32'd0,          32'd0};
    vecs[1]  = '{32'd1,          32'd1,          32'd0};
    vecs[2]  = '{32'd2,          32'd1,          32'd1};
    vecs[3]  = '{32'd3,          32'd1,          32'd2};
    vecs[4]  = '{32'd4,          32'd2,          32'd0};
    vecs[5]  = '{32'd15,         32'd3,          32'd6};
    vecs[6]  = '{32'd17,         32'd4,          32'd1};
    vecs[7]  = '{32'd1000000,    32'd1000,       32'd0};
    vecs[8]  = '{32'hFFFF_FFFF,  32'h0000_FFFF,  32'h0001_FFFE};
    vecs[9]  = '{32'hFFFE_0001,  32'h0000_FFFF,  32'd0};
    vecs[10] = '{32'h0001_0000,  32'd256,        32'd0};
    vecs[11] = '{32'h4000_0000,  32'd32768,      32'd0};

    // Reset state
    repeat (3) tick();
    chk("rst_result", {32'd0, result}, 64'd0);
    chk("rst_remainder", {32'd0, remainder}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    rst = 1'b1;
    tick();

    // Zero radicand: full latency and exactly HALF busy cycles
    busy_cnt = 0;
    issue(32'd0, 32'd0, 32'd0, 1'b1);
    wait_drain(40);
    tick();
    chk("busy_cycles", 64'(busy_cnt), 64'(HALF));

    foreach (vecs[i]) begin
      issue(vecs[i].rad, vecs[i].res, vecs[i].rem, 1'b1);
      wait_drain(40);
    end

    // Back-to-back: extra starts while busy are ignored, start in the done cycle is taken
    issue(32'h10, 32'd4, 32'd0, 1'b1);
    repeat (3) tick();
    issue(32'hFFFF_FFFF, 32'd0, 32'd0, 1'b0);
    repeat (5) tick();
    issue(32'd12345, 32'd0, 32'd0, 1'b0);
    repeat (LAT - 11) tick();
    chk("b2b_done_cycle", {63'd0, done}, 64'd1);
    issue(32'h51, 32'd9, 32'd0, 1'b1);
    wait_drain(40);
    tick();

    // Flush mid-operation: no done, outputs keep prior values
    issue(32'd17, 32'd4, 32'd1, 1'b1);
    wait_drain(40);
    issue(32'h90, 32'd0, 32'd0, 1'b0);
    repeat (4) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_busy", {63'd0, busy}, 64'd0);
    repeat (20) tick();
    chk("flush_result", {32'd0, result}, 64'd4);
    chk("flush_remainder", {32'd0, remainder}, 64'd1);
    // flush together with start in IDLE drops the start
    start = 1'b1; flush = 1'b1; radicand = 32'd81;
    tick();
    start = 1'b0; flush = 1'b0;
    chk("flush_start_busy", {63'd0, busy}, 64'd0);
    repeat (20) tick();
    issue(32'h64, 32'd10, 32'd0, 1'b1);
    wait_drain(40);

    // Reset mid-operation: no done, outputs cleared
    issue(32'h90, 32'd0, 32'd0, 1'b0);
    repeat (7) tick();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    repeat (20) tick();
    chk("rstmid_result", {32'd0, result}, 64'd0);
    chk("rstmid_remainder", {32'd0, remainder}, 64'd0);
    chk("rstmid_busy", {63'd0, busy}, 64'd0);

    // Random regression against the reference model
    for (int k = 0; k < 1500; k++) begin
      x  = $urandom();
      if (k % 4 == 1) x = x >> $urandom_range(31, 1);
      rs = ref_sqrt(x);
      issue(x, rs, x - rs * rs, 1'b1);
      wait_drain(40);
    end

    tick();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
